// File: rtl/operand_bypass_net.sv
// Operand-forwarding network: DEPTH-entry history of in-flight register writes,
// resolves two source operands against it and flags load-use stalls.
module operand_bypass_net #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    localparam int SW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_we,
    input  logic [AW-1:0]    push_rd,
    input  logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             fill_valid,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             flush,
    input  logic [AW-1:0]    rs_a,
    input  logic [AW-1:0]    rs_b,
    input  logic             rs_a_used,
    input  logic             rs_b_used,
    input  logic [WIDTH-1:0] rf_a,
    input  logic [WIDTH-1:0] rf_b,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [SW-1:0]    fwd_sel_a,
    output logic [SW-1:0]    fwd_sel_b,
    output logic             stall,
    output logic [15:0]      stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic             we;
        logic [AW-1:0]    rd;
        logic             ready;
        logic [WIDTH-1:0] data;
    } slot_t;

    slot_t hist [DEPTH];
    slot_t mod  [DEPTH];
    slot_t nxt  [DEPTH];

    logic [DEPTH-1:0] fill_oh;
    logic             fill_found;

    // Fill target is the youngest pending producer, picked from pre-edge state
    always_comb begin
        fill_found = 1'b0;
        fill_oh    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hist[i].valid && hist[i].we && !hist[i].ready && !fill_found) begin
                fill_oh[i] = 1'b1;
                fill_found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mod[i] = hist[i];
            if (fill_valid && fill_oh[i]) begin
                mod[i].data  = fill_data;
                mod[i].ready = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) nxt[i] = mod[i];
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) nxt[i] = mod[i-1];
            nxt[0] = '{valid: 1'b1, we: push_we, rd: push_rd, ready: push_ready, data: push_data};
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) nxt[i].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= nxt[i];
        end
    end

    logic [1:0][AW-1:0]    rs;
    logic [1:0][WIDTH-1:0] rf;
    logic [1:0][WIDTH-1:0] op;
    logic [1:0][WIDTH-1:0] fwd_data;
    logic [1:0][SW-1:0]    sel;
    logic [1:0]            used, hit, rdy, pend;

    assign rs   = {rs_b, rs_a};
    assign rf   = {rf_b, rf_a};
    assign used = {rs_b_used, rs_a_used};

    // Scan oldest to youngest so the lowest-index match wins
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hit[s]      = 1'b0;
            rdy[s]      = 1'b0;
            sel[s]      = '0;
            fwd_data[s] = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (hist[i].valid && hist[i].we && hist[i].rd == rs[s] && rs[s] != '0) begin
                    hit[s]      = 1'b1;
                    rdy[s]      = hist[i].ready;
                    sel[s]      = SW'(i + 1);
                    fwd_data[s] = hist[i].data;
                end
            end
            op[s]   = (hit[s] && rdy[s]) ? fwd_data[s] : rf[s];
            pend[s] = hit[s] && !rdy[s] && used[s];
        end
    end

    assign op_a      = op[0];
    assign op_b      = op[1];
    assign fwd_sel_a = sel[0];
    assign fwd_sel_b = sel[1];
    assign stall     = |pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/operand_bypass_net.md
# operand_bypass_net

Parametrised operand-forwarding network for the pipelined core. It generalises the fixed three-input forwarding select to a DEPTH-entry history of in-flight register writes, and tracks each entry's destination, readiness and result. It resolves both source operands against the register-file read data, and raises a load-use stall when the newest matching producer has no data yet. It sits between the register-file read in decode and the ALU operand inputs.

## Interface
- WIDTH, 32, data width.
- DEPTH, 3, in-flight write slots tracked; slot 0 is the youngest. Legal range is 1..7.
- AW, 5, register address width.
- SW, derived as $clog2(DEPTH+1), select width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  the pipeline advances; shift the history and insert a new slot 0.
- push_we  in  1  the new entry writes a register.
- push_rd  in  AW  destination of the new entry.
- push_ready  in  1  push_data is valid now (0 for loads).
- push_data  in  WIDTH  result of the new entry.
- fill_valid  in  1  late (load) data for the youngest pending entry.
- fill_data  in  WIDTH  late data.
- flush  in  1  invalidate all entries.
- rs_a, rs_b  in  AW  source addresses.
- rs_a_used, rs_b_used  in  1  the source is actually read by the instruction.
- rf_a, rf_b  in  WIDTH  register-file read data.
- op_a, op_b  out  WIDTH  resolved operands.
- fwd_sel_a, fwd_sel_b  out  SW  0 means register file; i+1 means slot i.
- stall  out  1  load-use hazard.
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Each slot holds {valid, we, rd, ready, data}.
- On push:
  - slot i+1 takes slot i; slot DEPTH-1 retires.
  - slot 0 takes {1, push_we, push_rd, push_ready, push_data}.
- Without push, the history holds.
- fill_valid writes fill_data into the youngest slot with valid & we & !ready, and sets ready.
  - The target is chosen from pre-edge state.
  - If push happens in the same cycle, the fill follows the entry to its shifted position. An entry shifted out of slot DEPTH-1 is lost.
  - fill with no pending entry is ignored.
- flush clears every valid bit. It takes priority over push and fill in the same cycle, and the pushed entry is discarded.
- Match for a source: slot valid & we & rd == rs & rs != 0.
- Resolution per source:
  - If no slot matches, op = rf and sel = 0.
  - Otherwise the youngest (lowest-index) matching slot i wins, and sel = i+1.
  - If that slot is ready, op = its data. If not ready, op = rf (don't-care).
- Register 0 is never forwarded. op = rf_x regardless of history.
- stall = (rs_a_used & newest match for a not ready) | (same for b).
  - An older ready match never hides a younger pending one.
  - An unused source never causes a stall.
- The block does not freeze itself. Upstream holds decode and pushes a bubble (push_we = 0) while stall is high.
- stall_cnt increments on every clock edge where stall = 1, and saturates at 0xFFFF. flush does not clear it; only reset does.

## Timing
- Reset (async, immediate): all slots invalid, stall_cnt = 0.
  - As a result op_a = rf_a, op_b = rf_b, fwd_sel = 0, stall = 0.
- op, fwd_sel and stall are combinational from the current history and the read addresses. They are valid in the same cycle.
- History updates take effect on the next rising edge after push, fill or flush.
- A pushed entry is visible to the forwarding logic one cycle after the push edge.
- Load-use case: push with push_ready = 0, then a dependent read in the next cycle gives stall = 1. A fill in that cycle clears the stall in the following cycle, and op then carries fill_data.
- Reset asserted mid-operation discards all entries and pending fills without completing them.

## Test plan
- Reset, then rs_a = 5 with rf_a = 0x11 -> op_a = 0x11, fwd_sel_a = 0, stall = 0, stall_cnt = 0.
- Push (rd = 5, data 0xAAAA, ready), then push (rd = 5, data 0xBBBB, ready); read rs_a = 5 -> op_a = 0xBBBB, fwd_sel_a = 1. After a third push of a bubble -> op_a = 0xBBBB, fwd_sel_a = 2.
- Push a load (rd = 7, not ready) with rs_b = 7 used -> stall = 1 and stall_cnt increments. Push a bubble together with fill 0x1234 -> next cycle stall = 0, op_b = 0x1234, fwd_sel_b = 2.
- Push (rd = 0, data 0xDEAD) and read rs_a = 0 with rf_a = 0 -> op_a = 0, fwd_sel_a = 0. A pending load to rd = 3 with rs_a_used = 0 -> stall = 0.
- A pending load in slot 0 for rd = 9, then flush and push on the same edge -> all entries invalid, rs = 9 reads rf, stall = 0.
- Hold stall high for 70000 cycles -> stall_cnt = 0xFFFF and it stays there; a mid-test reset -> stall_cnt = 0 and the history is empty immediately.
